// File: rtl/interrupt_sequencer_if.sv
// Signal bundle between the interrupt controller/CPU side and the interrupt sequencer.
// Handshake: cpu_intr is held high while a request is pending; the CPU accepts it with a one-cycle
// cpu_inta, or the sequencer withdraws cpu_intr if the request vanishes first. cpu_reti retires the service.
interface interrupt_sequencer_if;
  logic [5:0]  intr_Out;
  logic        int_en;
  logic        cpu_inta;
  logic        cpu_reti;
  logic        cpu_intr;
  logic        ISR_ld;
  logic        current_ISR_num_ld;
  logic        ISR_clr;
  logic [2:0]  isr_id;
  logic [15:0] vector;
  logic [1:0]  nest_lvl;
  logic        busy;
  logic [2:0]  state_dbg;

  modport master (
    output intr_Out, int_en, cpu_inta, cpu_reti,
    input  cpu_intr, ISR_ld, current_ISR_num_ld, ISR_clr, isr_id, vector, nest_lvl, busy, state_dbg
  );

  modport slave (
    input  intr_Out, int_en, cpu_inta, cpu_reti,
    output cpu_intr, ISR_ld, current_ISR_num_ld, ISR_clr, isr_id, vector, nest_lvl, busy, state_dbg
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: arbitrates requests, runs the CPU request/ack handshake and
// keeps a two-deep service stack so a fast interrupt can preempt a normal one.
module interrupt_sequencer #(
  parameter logic [15:0] VEC_BASE  = 16'h0100,
  parameter int          VEC_SHIFT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  interrupt_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_LOAD    = 3'd2,
    S_SERVICE = 3'd3,
    S_CLEAR   = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  stk0, stk1;
  logic        fast0, fast1;
  logic [1:0]  nest;
  logic [2:0]  pend_id;
  logic        top_fast;
  logic [5:0]  mask;
  logic [5:0]  req;
  logic [2:0]  win_id;
  logic        win_vld;
  logic [2:0]  id_out;

  function automatic logic [15:0] vec_of(input logic [2:0] id);
    logic [15:0] off;
    off = 16'(id) << VEC_SHIFT;
    return VEC_BASE + off;
  endfunction

  // Eligibility depends only on depth and fast flags, never on an out-of-range stack slot.
  always_comb begin
    top_fast = (nest == 2'd2) ? fast1 : fast0;
    mask     = 6'b000000;
    if (nest == 2'd0)
      mask = 6'b111111;
    else if (!top_fast && nest == 2'd1)
      mask = 6'b111000;
    req     = bus.int_en ? (bus.intr_Out & mask) : 6'b000000;
    win_id  = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (req[i]) win_id = 3'(i);
    end
    win_vld = |req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx               = state;
    bus.cpu_intr           = 1'b0;
    bus.ISR_ld             = 1'b0;
    bus.current_ISR_num_ld = 1'b0;
    bus.ISR_clr            = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_vld) state_nx = S_REQ;
      end
      S_REQ: begin
        bus.cpu_intr = 1'b1;
        if (!win_vld)
          state_nx = (nest == 2'd0) ? S_IDLE : S_SERVICE;
        else if (bus.cpu_inta)
          state_nx = S_LOAD;
      end
      S_LOAD: begin
        bus.ISR_ld             = 1'b1;
        bus.current_ISR_num_ld = 1'b1;
        state_nx               = S_SERVICE;
      end
      S_SERVICE: begin
        if (bus.cpu_reti)  state_nx = S_CLEAR;
        else if (win_vld)  state_nx = S_REQ;
      end
      S_CLEAR: begin
        bus.ISR_clr = 1'b1;
        state_nx    = (nest == 2'd2) ? S_SERVICE : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk0    <= 3'd0;
      stk1    <= 3'd0;
      fast0   <= 1'b0;
      fast1   <= 1'b0;
      nest    <= 2'd0;
      pend_id <= 3'd0;
    end else begin
      if (state == S_REQ && win_vld && bus.cpu_inta)
        pend_id <= win_id;
      if (state == S_LOAD) begin
        if (nest == 2'd0) begin
          stk0  <= pend_id;
          fast0 <= (pend_id >= 3'd3);
        end else begin
          stk1  <= pend_id;
          fast1 <= (pend_id >= 3'd3);
        end
        nest <= nest + 2'd1;
      end
      if (state == S_CLEAR)
        nest <= nest - 2'd1;
    end
  end

  // During LOAD the incoming ID is shown; otherwise the top of stack (retiring ID in CLEAR).
  always_comb begin
    if (state == S_LOAD)      id_out = pend_id;
    else if (nest == 2'd2)    id_out = stk1;
    else if (nest == 2'd1)    id_out = stk0;
    else                      id_out = 3'd0;
  end

  assign bus.isr_id    = id_out;
  assign bus.vector    = (state == S_LOAD || nest != 2'd0) ? vec_of(id_out) : 16'h0000;
  assign bus.nest_lvl  = nest;
  assign bus.busy      = (state != S_IDLE);
  assign bus.state_dbg = state;

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    (state == S_LOAD) |-> (nest != 2'd2));
  a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.ISR_ld && bus.ISR_clr));

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus randomized traffic
// compared against a stack/queue reference model.
module tb_interrupt_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [4:0] flags;

  interrupt_sequencer_if bus();

  interrupt_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {cpu_intr, ISR_ld, current_ISR_num_ld, ISR_clr, busy}
  assign flags = {bus.cpu_intr, bus.ISR_ld, bus.current_ISR_num_ld, bus.ISR_clr, bus.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.intr_Out = 6'b000000;
    bus.int_en   = 1'b1;
    bus.cpu_inta = 1'b0;
    bus.cpu_reti = 1'b0;
  endtask

  task automatic ack();
    bus.cpu_inta = 1'b1;
    tick();
    bus.cpu_inta = 1'b0;
  endtask

  task automatic retire();
    bus.cpu_reti = 1'b1;
    tick();
    bus.cpu_reti = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    total++;
    if (flags !== 5'b00000 || bus.nest_lvl !== 2'd0 || bus.isr_id !== 3'd0 ||
        bus.vector !== 16'h0000 || bus.state_dbg !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: flags=%b nest=%0d id=%0d vec=%h st=%0d required all 0",
               flags, bus.nest_lvl, bus.isr_id, bus.vector, bus.state_dbg);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_normal();
    bus.intr_Out = 6'b000001;
    tick();
    total++;
    if (flags !== 5'b10001) begin
      bad++; $display("FAIL single_req: flags=%b required 10001", flags);
    end
    repeat (3) tick();
    total++;
    if (flags !== 5'b10001) begin
      bad++; $display("FAIL single_req_hold: flags=%b required 10001", flags);
    end
    ack();
    bus.intr_Out = 6'b000000;
    total++;
    if (flags !== 5'b01101 || bus.isr_id !== 3'd0 || bus.vector !== 16'h0100) begin
      bad++; $display("FAIL single_load: flags=%b id=%0d vec=%h required 01101 0 0100",
                      flags, bus.isr_id, bus.vector);
    end
    tick();
    total++;
    if (flags !== 5'b00001 || bus.nest_lvl !== 2'd1 || bus.vector !== 16'h0100) begin
      bad++; $display("FAIL single_service: flags=%b nest=%0d vec=%h required 00001 1 0100",
                      flags, bus.nest_lvl, bus.vector);
    end
    repeat (4) tick();
    retire();
    total++;
    if (flags !== 5'b00011 || bus.isr_id !== 3'd0) begin
      bad++; $display("FAIL single_clear: flags=%b id=%0d required 00011 0", flags, bus.isr_id);
    end
    tick();
    total++;
    if (flags !== 5'b00000 || bus.nest_lvl !== 2'd0) begin
      bad++; $display("FAIL single_idle: flags=%b nest=%0d required 00000 0", flags, bus.nest_lvl);
    end
  endtask

  task automatic test_priority();
    bus.intr_Out = 6'b000101;
    tick();
    ack();
    bus.intr_Out = 6'b000000;
    total++;
    if (bus.isr_id !== 3'd2 || bus.vector !== 16'h0110) begin
      bad++; $display("FAIL prio_low: id=%0d vec=%h required 2 0110", bus.isr_id, bus.vector);
    end
    tick();
    retire();
    tick();
    bus.intr_Out = 6'b000101;
    tick();
    bus.intr_Out = 6'b100101;
    tick();
    total++;
    if (flags !== 5'b10001) begin
      bad++; $display("FAIL prio_rereq: flags=%b required 10001", flags);
    end
    ack();
    bus.intr_Out = 6'b000000;
    total++;
    if (flags !== 5'b01101 || bus.isr_id !== 3'd5 || bus.vector !== 16'h0128) begin
      bad++; $display("FAIL prio_replace: flags=%b id=%0d vec=%h required 01101 5 0128",
                      flags, bus.isr_id, bus.vector);
    end
    tick();
    retire();
    tick();
  endtask

  task automatic test_preemption();
    bus.intr_Out = 6'b000010;
    tick();
    ack();
    bus.intr_Out = 6'b000000;
    tick();
    bus.intr_Out = 6'b010000;
    tick();
    total++;
    if (flags !== 5'b10001 || bus.nest_lvl !== 2'd1) begin
      bad++; $display("FAIL preempt_req: flags=%b nest=%0d required 10001 1", flags, bus.nest_lvl);
    end
    ack();
    bus.intr_Out = 6'b000000;
    total++;
    if (flags !== 5'b01101 || bus.isr_id !== 3'd4 || bus.vector !== 16'h0120) begin
      bad++; $display("FAIL preempt_load: flags=%b id=%0d vec=%h required 01101 4 0120",
                      flags, bus.isr_id, bus.vector);
    end
    tick();
    total++;
    if (bus.nest_lvl !== 2'd2 || bus.isr_id !== 3'd4) begin
      bad++; $display("FAIL preempt_nest: nest=%0d id=%0d required 2 4", bus.nest_lvl, bus.isr_id);
    end
    retire();
    total++;
    if (flags !== 5'b00011 || bus.isr_id !== 3'd4) begin
      bad++; $display("FAIL preempt_clr_inner: flags=%b id=%0d required 00011 4", flags, bus.isr_id);
    end
    tick();
    total++;
    if (flags !== 5'b00001 || bus.isr_id !== 3'd1 || bus.nest_lvl !== 2'd1 || bus.vector !== 16'h0108) begin
      bad++; $display("FAIL preempt_restore: flags=%b id=%0d nest=%0d vec=%h required 00001 1 1 0108",
                      flags, bus.isr_id, bus.nest_lvl, bus.vector);
    end
    retire();
    total++;
    if (flags !== 5'b00011 || bus.isr_id !== 3'd1) begin
      bad++; $display("FAIL preempt_clr_outer: flags=%b id=%0d required 00011 1", flags, bus.isr_id);
    end
    tick();
    total++;
    if (flags !== 5'b00000 || bus.nest_lvl !== 2'd0) begin
      bad++; $display("FAIL preempt_idle: flags=%b nest=%0d required 00000 0", flags, bus.nest_lvl);
    end
  endtask

  task automatic test_back_to_back();
    bus.intr_Out = 6'b001000;
    tick();
    ack();
    bus.intr_Out = 6'b100001;
    total++;
    if (bus.isr_id !== 3'd3) begin
      bad++; $display("FAIL nopre_load: id=%0d required 3", bus.isr_id);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.cpu_intr !== 1'b0) begin
        bad++; $display("FAIL nopre_blocked: cycle=%0d cpu_intr=%b required 0", i, bus.cpu_intr);
      end
    end
    retire();
    total++;
    if (flags !== 5'b00011 || bus.isr_id !== 3'd3) begin
      bad++; $display("FAIL nopre_clear: flags=%b id=%0d required 00011 3", flags, bus.isr_id);
    end
    tick();
    total++;
    if (flags !== 5'b00000) begin
      bad++; $display("FAIL b2b_gap: flags=%b required 00000", flags);
    end
    tick();
    total++;
    if (flags !== 5'b10001) begin
      bad++; $display("FAIL b2b_req: flags=%b required 10001", flags);
    end
    ack();
    bus.intr_Out = 6'b000000;
    total++;
    if (bus.isr_id !== 3'd5 || bus.vector !== 16'h0128) begin
      bad++; $display("FAIL b2b_load: id=%0d vec=%h required 5 0128", bus.isr_id, bus.vector);
    end
    tick();
    retire();
    tick();
  endtask

  task automatic test_withdraw();
    bus.intr_Out = 6'b000100;
    tick();
    total++;
    if (flags !== 5'b10001) begin
      bad++; $display("FAIL wd_req: flags=%b required 10001", flags);
    end
    bus.intr_Out = 6'b000000;
    tick();
    total++;
    if (flags !== 5'b00000) begin
      bad++; $display("FAIL wd_drop: flags=%b required 00000", flags);
    end
    ack();
    total++;
    if (flags !== 5'b00000 || bus.nest_lvl !== 2'd0) begin
      bad++; $display("FAIL wd_stray_ack: flags=%b nest=%0d required 00000 0", flags, bus.nest_lvl);
    end
    bus.intr_Out = 6'b000100;
    tick();
    bus.int_en = 1'b0;
    tick();
    total++;
    if (flags !== 5'b00000) begin
      bad++; $display("FAIL wd_int_en: flags=%b required 00000", flags);
    end
    bus.int_en   = 1'b1;
    bus.intr_Out = 6'b000000;
    tick();
  endtask

  task automatic test_reset_mid_service();
    bus.intr_Out = 6'b000010;
    tick();
    ack();
    bus.intr_Out = 6'b000000;
    tick();
    bus.intr_Out = 6'b010000;
    tick();
    ack();
    bus.intr_Out = 6'b000000;
    tick();
    total++;
    if (bus.nest_lvl !== 2'd2) begin
      bad++; $display("FAIL rst_setup: nest=%0d required 2", bus.nest_lvl);
    end
    #2;
    reset        = 1'b1;
    bus.cpu_reti = 1'b1;
    #1;
    total++;
    if (flags !== 5'b00000 || bus.nest_lvl !== 2'd0 || bus.isr_id !== 3'd0 || bus.vector !== 16'h0000) begin
      bad++; $display("FAIL rst_async: flags=%b nest=%0d id=%0d vec=%h required all 0",
                      flags, bus.nest_lvl, bus.isr_id, bus.vector);
    end
    tick();
    bus.cpu_reti = 1'b0;
    reset        = 1'b0;
    tick();
    total++;
    if (flags !== 5'b00000 || bus.nest_lvl !== 2'd0) begin
      bad++; $display("FAIL rst_no_clr: flags=%b nest=%0d required 00000 0", flags, bus.nest_lvl);
    end
  endtask

  task automatic test_random();
    int       stk[$];
    bit       m_pend, m_load, m_clr;
    int       m_new;
    int       w;
    int       eid;
    logic [5:0]  elig;
    logic [4:0]  eflags;
    logic [15:0] evec;
    m_pend = 0; m_load = 0; m_clr = 0; m_new = 0;
    drive_idle();
    tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      eflags = {m_pend, m_load, m_load, m_clr, (m_pend || m_load || m_clr || stk.size() > 0)};
      total++;
      if (flags !== eflags) begin
        bad++; $display("FAIL rand_flags: cyc=%0d flags=%b required %b", cyc, flags, eflags);
      end
      total++;
      if (bus.nest_lvl !== 2'(stk.size())) begin
        bad++; $display("FAIL rand_nest: cyc=%0d nest=%0d required %0d", cyc, bus.nest_lvl, stk.size());
      end
      if (m_load || stk.size() > 0) begin
        eid  = m_load ? m_new : stk[$];
        evec = 16'h0100 + 16'(eid * 8);
        total++;
        if (bus.isr_id !== 3'(eid) || bus.vector !== evec) begin
          bad++; $display("FAIL rand_id: cyc=%0d id=%0d vec=%h required %0d %h",
                          cyc, bus.isr_id, bus.vector, eid, evec);
        end
      end

      for (int b = 0; b < 6; b++) bus.intr_Out[b] = ($urandom_range(0, 3) == 0);
      bus.int_en   = ($urandom_range(0, 9) != 0);
      bus.cpu_inta = ($urandom_range(0, 2) == 0);
      bus.cpu_reti = ($urandom_range(0, 4) == 0);

      if (stk.size() == 0)    elig = 6'b111111;
      else if (stk[$] >= 3)   elig = 6'b000000;
      else                    elig = 6'b111000;
      w = -1;
      if (bus.int_en)
        for (int b = 0; b < 6; b++) if (bus.intr_Out[b] && elig[b]) w = b;

      if (m_load) begin
        stk.push_back(m_new);
        m_load = 0;
      end else if (m_clr) begin
        void'(stk.pop_back());
        m_clr = 0;
      end else if (m_pend) begin
        if (w < 0) m_pend = 0;
        else if (bus.cpu_inta) begin
          m_pend = 0; m_load = 1; m_new = w;
        end
      end else if (stk.size() > 0 && bus.cpu_reti) begin
        m_clr = 1;
      end else if (w >= 0) begin
        m_pend = 1;
      end
      tick();
    end
    drive_idle();
    repeat (4) tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_normal();
    test_priority();
    test_preemption();
    test_back_to_back();
    test_withdraw();
    test_reset_mid_service();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Control FSM that sequences the interrupt controller datapath between the request vector and the CPU. It arbitrates the controller's `intr_Out` requests and runs the CPU request/acknowledge handshake. It drives the controller's `ISR_ld`, `current_ISR_num_ld` and `ISR_clr` strobes, and supplies the CPU with the active ID and vector. It supports one level of nesting: a fast interrupt may preempt a normal one.

## Interface
- `VEC_BASE`, default 16'h0100: vector base address.
- `VEC_SHIFT`, default 3: vector stride is 2^VEC_SHIFT bytes per ID.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `intr_Out`  in  6  request vector from the interrupt controller.
  - Bits [5:3] are fast requests; [2:0] are normal requests.
  - Higher bit index means higher priority.
- `int_en`  in  1  CPU global interrupt enable.
- `cpu_inta`  in  1  CPU acknowledge, one-cycle pulse at an instruction boundary.
- `cpu_reti`  in  1  CPU return-from-interrupt, one-cycle pulse.
- `cpu_intr`  out  1  interrupt request to the CPU.
- `ISR_ld`  out  1  one-cycle load strobe to the ISR register.
- `current_ISR_num_ld`  out  1  one-cycle load strobe to the current_ISR register.
- `ISR_clr`  out  1  one-cycle clear strobe to the ISR register.
- `isr_id`  out  3  ID (0–5, the bit index) being loaded, serviced or retired.
- `vector`  out  16  service address, VEC_BASE + (isr_id << VEC_SHIFT), modulo 2^16.
- `nest_lvl`  out  2  number of active services (0, 1 or 2).
- `busy`  out  1  high when state is not IDLE.

## Operation
- **States:** IDLE, REQ, LOAD, SERVICE, CLEAR.
- **Storage:** a 2-entry ID stack (`stk0` = outer, `stk1` = inner), a 1-bit fast flag per entry, and a 2-bit `nest_lvl`.
- **Eligible mask:**
  - `nest_lvl` = 0: all six bits are eligible.
  - Top-of-stack is normal and `nest_lvl` = 1: only [5:3] are eligible.
  - Top-of-stack is fast: nothing is eligible.
  - The masks are computed from `nest_lvl` and the fast flags; no stack contents are read out of range.
- **Winner:** the highest set bit of (`intr_Out` & mask), gated by `int_en`.
- **IDLE:** if the winner exists, go to REQ.
- **SERVICE:**
  - `cpu_reti` → CLEAR.
  - Else, if a winner exists (a fast preemption) → REQ.
  - If `cpu_reti` and a preempting request occur in the same cycle, `cpu_reti` wins.
- **REQ:**
  - `cpu_intr` = 1.
  - The winner is re-arbitrated every cycle, so a higher-priority arrival replaces the pending ID.
  - `cpu_inta` → LOAD, with the ID frozen at its value in the `cpu_inta` cycle.
  - If the winner disappears or `int_en` drops before `cpu_inta`: withdraw `cpu_intr` and return to the prior state (IDLE if `nest_lvl` = 0, else SERVICE).
- **LOAD (one cycle):**
  - `ISR_ld` = `current_ISR_num_ld` = 1.
  - Push the ID and its fast flag; `nest_lvl` += 1.
  - `isr_id` and `vector` update to the new ID.
  - Next state is SERVICE.
- **CLEAR (one cycle):**
  - `ISR_clr` = 1; `isr_id` shows the retiring ID.
  - Pop; `nest_lvl` -= 1.
  - Next state is SERVICE if the post-pop `nest_lvl` > 0, with `isr_id`/`vector` restored to the outer ID; else IDLE.
- **Ignored inputs:** `cpu_inta` outside REQ and `cpu_reti` outside SERVICE have no effect.
- **Stack depth:** `nest_lvl` never exceeds 2 by construction. A push at level 2 is unreachable; an assertion checks it.
- **Strobe exclusivity:** `ISR_ld` and `ISR_clr` are never high in the same cycle.

## Timing
- **Reset:** state = IDLE.
  - All strobes, `cpu_intr`, `busy`, `isr_id`, `nest_lvl` and the stack are 0.
  - `vector` = 0.
  - Assertion of reset mid-service aborts immediately, with no `ISR_clr` pulse.
- **Outputs:** all outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- **Request:** a request visible at edge n gives `cpu_intr` high in cycle n+1.
- **Acknowledge:** `cpu_inta` sampled at edge m gives:
  - `ISR_ld`/`current_ISR_num_ld` high in cycle m+1 only;
  - `isr_id`/`vector` valid from m+1, held through SERVICE.
- **Return:** `cpu_reti` sampled at edge k gives:
  - `ISR_clr` high in cycle k+1, with the retiring ID;
  - the restored ID, or IDLE, from k+2.
- **Back-to-back:** a new request is seen at the earliest in the cycle after CLEAR, so `cpu_intr` is high at k+3.
- **Withdraw:** `cpu_intr` falls in the cycle after the winner disappears.

## Test plan
- **Single normal request:** `intr_Out`=6'b000001, `int_en`=1, `cpu_inta` at cycle 5.
  - `cpu_intr` high from cycle 2.
  - `ISR_ld` pulses at 6; `isr_id`=0; `vector`=16'h0100.
  - `cpu_reti` at 20 → `ISR_clr` at 21, IDLE at 22.
- **Priority:** `intr_Out`=6'b000101.
  - `isr_id`=2, `vector`=16'h0110.
  - While in REQ, bit 5 also rises → ID becomes 5 before ack (`vector`=16'h0128).
- **Preemption:** serve normal ID 1, then raise bit 4.
  - REQ → LOAD with `nest_lvl`=2, `isr_id`=4.
  - First `cpu_reti`: `ISR_clr` with ID 4, then `isr_id` restored to 1, `nest_lvl`=1.
  - Second `cpu_reti`: IDLE.
- **No preemption:** while serving fast ID 3, raise bits 5 and 0. `cpu_intr` stays low until after CLEAR; then ID 5 is served.
- **Withdraw:** raise bit 2, drop it (or drop `int_en`) before `cpu_inta`.
  - `cpu_intr` falls the next cycle; no strobes.
  - A later `cpu_inta` is ignored.
- **Reset mid-service:** assert `reset` asynchronously in SERVICE at `nest_lvl`=2. All outputs are 0 immediately; there is no `ISR_clr`.
